// File: rtl/ex_multdiv_pipe.sv
// ex_multdiv_pipe: EX-stage back end. Merges the ALU, CSR and RV32M results into
// the EX->LSU pipeline register. Includes an iterative multiply/divide unit that
// stalls the front of the pipeline while it works.
// Optional build macro: MULDIV_FAST_MUL_EN (multiplies finish in one cycle).
module ex_multdiv_pipe #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  input  logic [XLEN-1:0]      alu_result_i,
  input  logic                 csr_wb_flag_i,
  input  logic [XLEN-1:0]      csr_rdata_i,
  input  logic                 multdiv_en_i,
  input  logic [2:0]           multdiv_op_i,
  input  logic [XLEN-1:0]      operand_a_i,
  input  logic [XLEN-1:0]      operand_b_i,
  input  logic [XLEN-1:0]      operand_imm_i,
  input  logic                 wb_flag_i,
  input  logic [REGADDR_W-1:0] wb_addr_i,
  input  logic                 load_flag_i,
  input  logic                 store_flag_i,
  input  logic [1:0]           lsu_type_i,
  input  logic                 lsu_signed_i,
  input  logic                 hold_i,
  input  logic                 flush_i,
  output logic                 multdiv_hold_o,
  output logic                 busy_o,
  output logic                 out_valid_o,
  output logic                 wb_flag_o,
  output logic                 load_flag_o,
  output logic                 store_flag_o,
  output logic                 lsu_signed_o,
  output logic [1:0]           lsu_type_o,
  output logic [REGADDR_W-1:0] wb_addr_o,
  output logic [XLEN-1:0]      operand_a_o,
  output logic [XLEN-1:0]      operand_b_o,
  output logic [XLEN-1:0]      operand_imm_o,
  output logic [XLEN-1:0]      wb_data_o
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] SIGN_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] { IDLE, CALC, DONE } mdState_e;

  mdState_e          state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2:0]        op_q, op_d;
  logic              negQ_q, negQ_d;
  logic              negR_q, negR_d;
  logic              noCorr_q, noCorr_d;

  // Operand decode: magnitudes and signs of the incoming RV-M operands
  logic            isDivIn, aSignedIn, bSignedIn, aNeg, bNeg, divZero, divOvf, mdStart;
  logic [XLEN-1:0] aAbs, bAbs;

  assign isDivIn   = multdiv_op_i[2];
  assign aSignedIn = (multdiv_op_i == 3'd1) || (multdiv_op_i == 3'd2) ||
                     (multdiv_op_i == 3'd4) || (multdiv_op_i == 3'd6);
  assign bSignedIn = (multdiv_op_i == 3'd1) || (multdiv_op_i == 3'd4) ||
                     (multdiv_op_i == 3'd6);
  assign aNeg      = aSignedIn & operand_a_i[XLEN-1];
  assign bNeg      = bSignedIn & operand_b_i[XLEN-1];
  assign aAbs      = aNeg ? -operand_a_i : operand_a_i;
  assign bAbs      = bNeg ? -operand_b_i : operand_b_i;
  assign divZero   = isDivIn & (operand_b_i == '0);
  assign divOvf    = isDivIn & ~multdiv_op_i[0] & (operand_a_i == SIGN_MIN) & (&operand_b_i);
  assign mdStart   = in_valid_i & multdiv_en_i & ~flush_i & ~hold_i;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0] fastA, fastB;
  logic [2*XLEN-1:0]    fastProd;
  assign fastA    = {aSignedIn & operand_a_i[XLEN-1], operand_a_i};
  assign fastB    = {bSignedIn & operand_b_i[XLEN-1], operand_b_i};
  assign fastProd = (2*XLEN)'(fastA) * (2*XLEN)'(fastB);
`endif

  // One iteration step: shift-add multiply (acc = {hi, multiplier}) and
  // restoring divide (acc = {remainder, dividend/quotient})
  logic [XLEN:0]     mulSum, divTrial;
  logic [2*XLEN-1:0] mulNext, divNext;

  assign mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({1'b0, mcand_q} & {(XLEN+1){acc_q[0]}});
  assign mulNext  = {mulSum, acc_q[XLEN-1:1]};
  assign divTrial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, mcand_q};
  assign divNext  = divTrial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                   : {divTrial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  // Sign correction and half/quotient/remainder selection of the finished result
  logic [2*XLEN-1:0] prodFix;
  logic [XLEN-1:0]   quoFix, remFix, mdResult;

  always_comb begin
    prodFix = (negQ_q & ~noCorr_q) ? -acc_q : acc_q;
    quoFix  = acc_q[XLEN-1:0];
    remFix  = acc_q[2*XLEN-1:XLEN];
    if (!noCorr_q) begin
      if (negQ_q) quoFix = -acc_q[XLEN-1:0];
      if (negR_q) remFix = -acc_q[2*XLEN-1:XLEN];
    end
    case (op_q)
      3'd0:                mdResult = prodFix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    mdResult = prodFix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          mdResult = quoFix;
      default:             mdResult = remFix;
    endcase
  end

  // Multiply/divide FSM next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    op_d     = op_q;
    negQ_d   = negQ_q;
    negR_d   = negR_q;
    noCorr_d = noCorr_q;
    case (state_q)
      IDLE: begin
        if (mdStart) begin
          op_d     = multdiv_op_i;
          cnt_d    = '0;
          acc_d    = {{XLEN{1'b0}}, aAbs};
          mcand_d  = bAbs;
          negQ_d   = aNeg ^ bNeg;
          negR_d   = aNeg;
          noCorr_d = 1'b0;
          state_d  = CALC;
          if (divZero) begin
            acc_d    = {operand_a_i, {XLEN{1'b1}}};
            noCorr_d = 1'b1;
            state_d  = DONE;
          end else if (divOvf) begin
            acc_d    = {{XLEN{1'b0}}, operand_a_i};
            noCorr_d = 1'b1;
            state_d  = DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!isDivIn) begin
            acc_d    = fastProd;
            noCorr_d = 1'b1;
            state_d  = DONE;
          end
`endif
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d = op_q[2] ? divNext : mulNext;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (flush_i || !hold_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Multiply/divide FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      op_q     <= '0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      noCorr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      op_q     <= op_d;
      negQ_q   <= negQ_d;
      negR_q   <= negR_d;
      noCorr_q <= noCorr_d;
    end
  end

  assign multdiv_hold_o = in_valid_i & multdiv_en_i & (state_q != DONE);
  assign busy_o         = (state_q != IDLE);

  logic [XLEN-1:0] wbDataIn;
  assign wbDataIn = csr_wb_flag_i ? csr_rdata_i : (multdiv_en_i ? mdResult : alu_result_i);

  logic                 outValid_q, wbFlag_q, loadFlag_q, storeFlag_q, lsuSigned_q;
  logic [1:0]           lsuType_q;
  logic [REGADDR_W-1:0] wbAddr_q;
  logic [XLEN-1:0]      opA_q, opB_q, opImm_q, wbData_q;

  // EX->LSU pipeline register: flush and RV-M bubbles kill the control bits only
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q  <= 1'b0;
      wbFlag_q    <= 1'b0;
      loadFlag_q  <= 1'b0;
      storeFlag_q <= 1'b0;
      lsuSigned_q <= 1'b0;
      lsuType_q   <= '0;
      wbAddr_q    <= '0;
      opA_q       <= '0;
      opB_q       <= '0;
      opImm_q     <= '0;
      wbData_q    <= '0;
    end else if (flush_i || (!hold_i && multdiv_hold_o)) begin
      outValid_q  <= 1'b0;
      wbFlag_q    <= 1'b0;
      loadFlag_q  <= 1'b0;
      storeFlag_q <= 1'b0;
    end else if (!hold_i) begin
      outValid_q  <= in_valid_i;
      wbFlag_q    <= wb_flag_i;
      loadFlag_q  <= load_flag_i;
      storeFlag_q <= store_flag_i;
      lsuSigned_q <= lsu_signed_i;
      lsuType_q   <= lsu_type_i;
      wbAddr_q    <= wb_addr_i;
      opA_q       <= operand_a_i;
      opB_q       <= operand_b_i;
      opImm_q     <= operand_imm_i;
      wbData_q    <= wbDataIn;
    end
  end

  assign out_valid_o   = outValid_q;
  assign wb_flag_o     = wbFlag_q;
  assign load_flag_o   = loadFlag_q;
  assign store_flag_o  = storeFlag_q;
  assign lsu_signed_o  = lsuSigned_q;
  assign lsu_type_o    = lsuType_q;
  assign wb_addr_o     = wbAddr_q;
  assign operand_a_o   = opA_q;
  assign operand_b_o   = opB_q;
  assign operand_imm_o = opImm_q;
  assign wb_data_o     = wbData_q;

endmodule

// File: doc/ex_multdiv_pipe.md
Name: ex_multdiv_pipe

Overview:
Parametrised EX-stage back end. It merges the ALU, CSR and multiply/divide results and registers them, with the control and operand fields, into the EX→LSU pipeline register. It contains an iterative RV32M multiply/divide unit that stalls the front of the pipeline through multdiv_hold_o. It sits between the combinational ALU/CLINT logic and the LSU stage, and adds a valid bit, flush and bubble insertion.

Parameters:
XLEN, 32, datapath width (even, ≥8)
REGADDR_W, 5, register-file address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid_i  in  1  EX holds a valid instruction
alu_result_i  in  XLEN  ALU result
csr_wb_flag_i  in  1  result comes from CSR
csr_rdata_i  in  XLEN  CSR read data
multdiv_en_i  in  1  instruction is RV-M
multdiv_op_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
operand_a_i / operand_b_i / operand_imm_i  in  XLEN  rs1, rs2, immediate
wb_flag_i  in  1  write-back enable
wb_addr_i  in  REGADDR_W  destination register
load_flag_i / store_flag_i  in  1  LSU access type
lsu_type_i  in  2  access size
lsu_signed_i  in  1  sign-extend load
hold_i  in  1  controller stall of EX→LSU register
flush_i  in  1  kill instruction in EX
multdiv_hold_o  out  1  request stall while RV-M is in progress
busy_o  out  1  FSM not IDLE
out_valid_o, wb_flag_o, load_flag_o, store_flag_o, lsu_signed_o  out  1  registered
lsu_type_o  out  2;  wb_addr_o  out  REGADDR_W
operand_a_o / operand_b_o / operand_imm_o / wb_data_o  out  XLEN  registered

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. All outputs reset to 0 and the FSM resets to IDLE.
- Result mux: csr_wb_flag_i selects csr_rdata_i; otherwise multdiv_en_i selects the md result; otherwise alu_result_i.
- Pipe register priority:
  - rst
  - flush_i: out_valid_o, wb_flag_o, load_flag_o and store_flag_o clear; data fields hold
  - hold_i: all fields hold
  - multdiv_hold_o: bubble; same fields cleared as for flush
  - otherwise capture all fields; out_valid_o <= in_valid_i
- multdiv_hold_o = in_valid_i & multdiv_en_i & (state != DONE). This is combinational.
- FSM IDLE:
  - Triggers on in_valid_i & multdiv_en_i & !flush_i & !hold_i.
  - Latches |a| and |b| per op signedness and records the result sign. MULHSU treats only a as signed.
  - Clears the counter (width clog2(XLEN+1)).
  - Goes to DONE for a divide special case, else to CALC.
- FSM CALC:
  - One iteration per cycle. Multiply is shift-add into a 2·XLEN accumulator; divide is restoring, one quotient bit per cycle.
  - Goes to DONE after XLEN iterations.
- FSM DONE:
  - Result is sign-corrected. The product is negated if the operand signs differ. The quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half; DIV/DIVU return the quotient; REM/REMU return the remainder.
  - Stays in DONE while hold_i is high; otherwise returns to IDLE (the result is captured this cycle).
- Latency (iterative op accepted in cycle T): CALC spans T+1..T+XLEN; DONE at T+XLEN+1. multdiv_hold_o is high for XLEN+1 cycles, and out_valid_o rises at T+XLEN+2.
- Divide special cases (DONE at T+1, hold for 1 cycle):
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder = 0.
- flush_i or rst in CALC or DONE aborts to IDLE next cycle; no result is produced.
- An in_valid_i drop mid-operation is illegal; the controller guarantees it does not happen.

Optional Feature:
MULDIV_FAST_MUL_EN defined:
- MUL* ops compute a combinational signed (XLEN+1)×(XLEN+1) product in IDLE and go straight to DONE, so hold lasts 1 cycle.
- Divide is unchanged.

Undefined:
- All multiplies are iterative, as above.

Test Plan:
- ALU passthrough: alu_result_i=0x12345678, wb_addr_i=5, in_valid_i=1 → next cycle out_valid_o=1, wb_data_o=0x12345678, wb_addr_o=5, multdiv_hold_o=0.
- MUL a=0xFFFFFFFD, b=7:
  - MUL → 0xFFFFFFEB, hold 33 cycles.
  - MULH → 0xFFFFFFFF.
  - MULHU → 0x00000006.
  - With MULDIV_FAST_MUL_EN, the same results with hold for 1 cycle.
- DIV a=100, b=0 → 0xFFFFFFFF with hold for 1 cycle; REMU → 100.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM → 0.
- DIV a=−7, b=2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- Flush and hold:
  - flush_i at the 10th CALC cycle → out_valid_o stays 0, busy_o=0 next cycle, and the following ALU op passes.
  - hold_i held 3 cycles in DONE → result is retained and captured once hold_i drops.
